// File: rtl/fir_block_sequencer_if.sv
// Signal bundle between the FIR block sequencer, the audio sample source/sink and
// the filter core. The master side is the sequencer; the slave side is its environment.
interface fir_block_sequencer_if #(
    parameter int SAMPLES_NUM = 4
) ();
    logic                        sample_valid;
    logic [15:0]                 sample;
    logic                        sample_ready;
    logic                        fir_start;
    logic [16*SAMPLES_NUM-1:0]   fir_data;
    logic                        fir_busy;
    logic                        fir_done;
    logic [32*SAMPLES_NUM-1:0]   fir_result;
    logic                        result_valid;
    logic [15:0]                 result;
    logic                        result_sat;
    logic                        result_ready;
    logic                        error;

    modport master (
        input  sample_valid, sample, fir_busy, fir_done, fir_result, result_ready,
        output sample_ready, fir_start, fir_data, result_valid, result, result_sat, error
    );

    modport slave (
        output sample_valid, sample, fir_busy, fir_done, fir_result, result_ready,
        input  sample_ready, fir_start, fir_data, result_valid, result, result_sat, error
    );
endinterface

// File: rtl/fir_block_sequencer.sv
// Gathers samples into blocks, runs the FIR core once per block, then streams the
// rounded/shifted/saturated lane results out over a valid/ready handshake.
module fir_block_sequencer #(
    parameter int SAMPLES_NUM    = 4,
    parameter int OUT_SHIFT      = 15,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input logic                   clk,
    input logic                   rst,
    fir_block_sequencer_if.master bus
);
    localparam int DATA_W = 16 * SAMPLES_NUM;
    localparam int RES_W  = 32 * SAMPLES_NUM;
    localparam int LANE_W = (SAMPLES_NUM > 1) ? $clog2(SAMPLES_NUM) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(SAMPLES_NUM - 1);
    localparam logic [CNT_W-1:0]   LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic signed [32:0] ROUND     = 33'sd1 <<< (OUT_SHIFT - 1);
    localparam logic signed [32:0] SAT_MAX   = 33'sd32767;
    localparam logic signed [32:0] SAT_MIN   = -33'sd32768;

    typedef enum logic [1:0] {COLLECT, START, WAIT, EMIT} state_t;

    state_t              state,        state_n;
    logic                sample_ready, sample_ready_n;
    logic                fir_start,    fir_start_n;
    logic [DATA_W-1:0]   fir_data,     fir_data_n;
    logic                result_valid, result_valid_n;
    logic [15:0]         result,       result_n;
    logic                result_sat,   result_sat_n;
    logic                error,        error_n;
    logic [RES_W-1:0]    lanes,        lanes_n;
    logic [LANE_W-1:0]   lane_cnt,     lane_cnt_n;
    logic [LANE_W-1:0]   sample_cnt,   sample_cnt_n;
    logic [CNT_W-1:0]    wait_cnt,     wait_cnt_n;

    // Lane 0 sits in the most significant 32 bits of the result bus.
    function automatic logic [31:0] lane_of(input logic [RES_W-1:0] vec, input logic [LANE_W-1:0] idx);
        return vec[RES_W - 32*int'(idx) - 1 -: 32];
    endfunction

    // Returns {saturated, sample}; 33 bits keep the rounding add from overflowing.
    function automatic logic [16:0] convert(input logic [31:0] lane);
        logic signed [32:0] rounded;
        logic signed [32:0] shifted;
        rounded = $signed({lane[31], lane}) + ROUND;
        shifted = rounded >>> OUT_SHIFT;
        if (shifted > SAT_MAX)
            return {1'b1, 16'h7fff};
        else if (shifted < SAT_MIN)
            return {1'b1, 16'h8000};
        return {1'b0, shifted[15:0]};
    endfunction

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_n        = state;
        sample_ready_n = 1'b0;
        fir_start_n    = 1'b0;
        fir_data_n     = fir_data;
        result_valid_n = result_valid;
        result_n       = result;
        result_sat_n   = result_sat;
        error_n        = 1'b0;
        lanes_n        = lanes;
        lane_cnt_n     = lane_cnt;
        sample_cnt_n   = sample_cnt;
        wait_cnt_n     = wait_cnt;

        case (state)
            COLLECT: begin
                sample_ready_n = 1'b1;
                if (bus.sample_valid && sample_ready) begin
                    fir_data_n = DATA_W'({fir_data, bus.sample});
                    if (sample_cnt == LAST_LANE) begin
                        sample_cnt_n   = '0;
                        sample_ready_n = 1'b0;
                        state_n        = START;
                    end else begin
                        sample_cnt_n = sample_cnt + 1'b1;
                    end
                end
            end
            START: begin
                if (!bus.fir_busy) begin
                    fir_start_n = 1'b1;
                    wait_cnt_n  = '0;
                    state_n     = WAIT;
                end
            end
            WAIT: begin
                // A done seen alongside our own start pulse belongs to no run of ours.
                if (bus.fir_done && !fir_start) begin
                    lanes_n                      = bus.fir_result;
                    {result_sat_n, result_n}     = convert(lane_of(bus.fir_result, '0));
                    result_valid_n               = 1'b1;
                    lane_cnt_n                   = '0;
                    state_n                      = EMIT;
                end else if (wait_cnt == LAST_WAIT) begin
                    error_n        = 1'b1;
                    sample_ready_n = 1'b1;
                    state_n        = COLLECT;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            EMIT: begin
                if (result_valid && bus.result_ready) begin
                    if (lane_cnt == LAST_LANE) begin
                        result_valid_n = 1'b0;
                        sample_ready_n = 1'b1;
                        state_n        = COLLECT;
                    end else begin
                        lane_cnt_n               = lane_cnt + 1'b1;
                        {result_sat_n, result_n} = convert(lane_of(lanes, lane_cnt + 1'b1));
                    end
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    // NOTE: the captured lane store is reset too, so a reset mid-run leaves no stale results behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= COLLECT;
            sample_ready <= 1'b0;
            fir_start    <= 1'b0;
            fir_data     <= '0;
            result_valid <= 1'b0;
            result       <= '0;
            result_sat   <= 1'b0;
            error        <= 1'b0;
            lanes        <= '0;
            lane_cnt     <= '0;
            sample_cnt   <= '0;
            wait_cnt     <= '0;
        end else begin
            state        <= state_n;
            sample_ready <= sample_ready_n;
            fir_start    <= fir_start_n;
            fir_data     <= fir_data_n;
            result_valid <= result_valid_n;
            result       <= result_n;
            result_sat   <= result_sat_n;
            error        <= error_n;
            lanes        <= lanes_n;
            lane_cnt     <= lane_cnt_n;
            sample_cnt   <= sample_cnt_n;
            wait_cnt     <= wait_cnt_n;
        end
    end

    assign bus.sample_ready = sample_ready;
    assign bus.fir_start    = fir_start;
    assign bus.fir_data     = fir_data;
    assign bus.result_valid = result_valid;
    assign bus.result       = result;
    assign bus.result_sat   = result_sat;
    assign bus.error        = error;
endmodule

// File: tb/tb_fir_block_sequencer.sv
// Bench for fir_block_sequencer: fixed vector table, hand-written corner sequences
// and random blocks checked against an arithmetic model of the lane conversion.
module tb_fir_block_sequencer;
    localparam int N       = 4;
    localparam int SHIFT   = 15;
    localparam int TIMEOUT = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fir_block_sequencer_if #(.SAMPLES_NUM(N)) bus ();

    fir_block_sequencer #(
        .SAMPLES_NUM   (N),
        .OUT_SHIFT     (SHIFT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:3][15:0] s;     // samples in arrival order
        logic [63:0]      data;  // expected packed block
        logic [0:3][31:0] l;     // lane results, lane 0 first
        logic [0:3][15:0] res;   // expected output samples
        logic [0:3]       sat;   // expected saturation flags
    } vec_t;

    vec_t tbl [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-half-up division by 2^SHIFT written as floor division, then clamp.
    function automatic logic [16:0] model(input logic [31:0] lane);
        longint div = longint'(1) << SHIFT;
        longint num = longint'($signed(lane)) + (div / 2);
        longint q;
        if (num >= 0) q = num / div;
        else          q = -((-num + div - 1) / div);
        if (q > 32767)  return {1'b1, 16'h7fff};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, q[15:0]};
    endfunction

    function automatic logic [127:0] pack(input logic [0:3][31:0] l);
        logic [127:0] p = '0;
        for (int k = 0; k < N; k++) p[32*(N-1-k) +: 32] = l[k];
        return p;
    endfunction

    function automatic logic [31:0] rand_lane();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return {{8{r[23]}}, r[23:0]};
            2:       return 32'h3fffc000 + 32'($urandom_range(0, 64)) - 32'd32;
            default: return 32'hc0000000 + 32'($urandom_range(0, 64)) - 32'd32;
        endcase
    endfunction

    function automatic vec_t make_random();
        vec_t v;
        logic [16:0] m;
        v = '0;
        for (int k = 0; k < N; k++) begin
            v.s[k] = 16'($urandom);
            v.data[16*(N-1-k) +: 16] = v.s[k];
            v.l[k] = rand_lane();
            m = model(v.l[k]);
            v.sat[k] = m[16];
            v.res[k] = m[15:0];
        end
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_sample_ready"}, bus.sample_ready, 0);
        check({tag, "_fir_start"},    bus.fir_start, 0);
        check({tag, "_fir_data"},     bus.fir_data, 0);
        check({tag, "_result_valid"}, bus.result_valid, 0);
        check({tag, "_result"},       bus.result, 0);
        check({tag, "_result_sat"},   bus.result_sat, 0);
        check({tag, "_error"},        bus.error, 0);
    endtask

    task automatic push(input logic [15:0] v);
        bit was_ready;
        int guard = 0;
        bus.sample_valid = 1'b1;
        bus.sample       = v;
        do begin
            was_ready = bus.sample_ready;
            tick();
            guard++;
        end while (!was_ready && guard < 50);
        check("push_accept", was_ready, 1);
        bus.sample_valid = 1'b0;
    endtask

    // One block end to end; stop_after < N abandons the drain after that many beats.
    task automatic run_block(input vec_t v, input int busy_cycles, input int done_delay,
                             input int hold_cycles, input bit rnd, input int stop_after);
        int held = 0;
        int guard;
        bit rdy;
        bus.fir_busy = (busy_cycles > 0);
        bus.fir_done = rnd;  // done outside WAIT must be ignored
        for (int k = 0; k < N; k++) begin
            if (rnd) repeat ($urandom_range(0, 2)) tick();
            push(v.s[k]);
        end
        bus.fir_done = 1'b0;
        check("ready_drop", bus.sample_ready, 0);
        check("start_not_yet", bus.fir_start, 0);
        check("fir_data", bus.fir_data, v.data);
        for (int i = 0; i < busy_cycles; i++) begin
            tick();
            check("busy_no_start", bus.fir_start, 0);
        end
        bus.fir_busy = 1'b0;
        tick();
        check("start_pulse", bus.fir_start, 1);
        // A done in the start cycle with junk results, plus a sample offered outside COLLECT.
        bus.fir_done     = 1'b1;
        bus.fir_result   = ~pack(v.l);
        bus.sample_valid = 1'b1;
        bus.sample       = 16'hdead;
        tick();
        bus.fir_done = 1'b0;
        check("start_single", bus.fir_start, 0);
        check("no_early_valid", bus.result_valid, 0);
        check("data_stable", bus.fir_data, v.data);
        repeat (done_delay) begin
            tick();
            check("wait_idle", bus.result_valid, 0);
        end
        bus.fir_done   = 1'b1;
        bus.fir_result = pack(v.l);
        tick();
        bus.fir_done     = 1'b0;
        bus.fir_result   = '0;
        bus.sample_valid = 1'b0;
        check("valid_rise", bus.result_valid, 1);
        for (int k = 0; k < stop_after; k++) begin
            guard = 0;
            do begin
                if (rnd) rdy = ($urandom_range(0, 2) != 0) || (guard > 20);
                else     rdy = (k != 0) || (held >= hold_cycles);
                bus.result_ready = rdy;
                check($sformatf("valid%0d", k), bus.result_valid, 1);
                check($sformatf("res%0d", k), bus.result, v.res[k]);
                check($sformatf("sat%0d", k), bus.result_sat, v.sat[k]);
                check("emit_no_accept", bus.sample_ready, 0);
                tick();
                if (!rdy) held++;
                guard++;
            end while (!rdy);
        end
        bus.result_ready = 1'b0;
        if (stop_after == N) begin
            check("drain_valid_low", bus.result_valid, 0);
            check("collect_ready", bus.sample_ready, 1);
        end
    endtask

    initial begin
        int  n;
        bit  saw_valid;

        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.fir_busy     = 1'b0;
        bus.fir_done     = 1'b0;
        bus.fir_result   = '0;
        bus.result_ready = 1'b0;

        tbl[0].s    = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
        tbl[0].data = 64'h0001_0002_0003_0004;
        tbl[0].l    = {32'h00008000, 32'h7fffffff, 32'h80000000, 32'hffff4000};
        tbl[0].res  = {16'h0001, 16'h7fff, 16'h8000, 16'hffff};
        tbl[0].sat  = 4'b0110;

        tbl[1].s    = {16'h8000, 16'h7fff, 16'hffff, 16'h0000};
        tbl[1].data = 64'h8000_7fff_ffff_0000;
        tbl[1].l    = {32'h00000000, 32'h00003fff, 32'hffffc000, 32'h3fff8000};
        tbl[1].res  = {16'h0000, 16'h0000, 16'h0000, 16'h7fff};
        tbl[1].sat  = 4'b0000;

        tbl[2].s    = {16'ha5a5, 16'h5a5a, 16'h0f0f, 16'hf0f0};
        tbl[2].data = 64'ha5a5_5a5a_0f0f_f0f0;
        tbl[2].l    = {32'h3fffc000, 32'hc0000000, 32'hbfffc000, 32'hbfff8000};
        tbl[2].res  = {16'h7fff, 16'h8000, 16'h8000, 16'h8000};
        tbl[2].sat  = 4'b1001;

        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("ready_after_reset", bus.sample_ready, 1);

        for (int i = 0; i < 3; i++) run_block(tbl[i], 0, i, 0, 1'b0, N);

        // Sink stalls five cycles on the first beat.
        run_block(tbl[0], 0, 1, 5, 1'b0, N);

        // Filter still busy when the block fills.
        run_block(tbl[1], 3, 0, 0, 1'b0, N);

        // No done at all: watchdog fires, nothing is emitted.
        for (int k = 0; k < N; k++) push(16'(k + 16'h10));
        tick();
        check("to_start", bus.fir_start, 1);
        n = 0;
        saw_valid = 1'b0;
        while (!bus.error && n < TIMEOUT + 20) begin
            tick();
            n++;
            if (bus.result_valid) saw_valid = 1'b1;
        end
        check("to_error_seen", bus.error, 1);
        check("to_latency", (n >= TIMEOUT - 1) && (n <= TIMEOUT + 1), 1);
        check("to_no_beats", saw_valid, 0);
        tick();
        check("to_error_pulse", bus.error, 0);
        check("to_ready", bus.sample_ready, 1);
        bus.fir_done   = 1'b1;
        bus.fir_result = pack(tbl[0].l);
        tick();
        bus.fir_done = 1'b0;
        repeat (3) begin
            tick();
            check("late_done_ignored", bus.result_valid, 0);
        end
        run_block(tbl[2], 0, 2, 0, 1'b0, N);

        // Reset after two beats of a block.
        run_block(tbl[2], 0, 0, 0, 1'b0, 2);
        rst = 1'b1;
        tick();
        check_all_zero("mid_reset_a");
        tick();
        check_all_zero("mid_reset_b");
        rst = 1'b0;
        tick();
        check("rel_ready", bus.sample_ready, 1);
        check("rel_no_valid", bus.result_valid, 0);
        run_block(tbl[0], 0, 0, 0, 1'b0, N);

        for (int i = 0; i < 20; i++)
            run_block(make_random(), $urandom_range(0, 2), $urandom_range(0, 4), 0, 1'b1, N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end
endmodule
